// File: rtl/decode_pkg.sv
// Shared pipeline definitions: instruction word layout, class codes, PC-redirect encodings.
package decode_pkg;

   localparam int unsigned WORD_W    = 16;
   localparam int unsigned FETCH_W   = 32;
   localparam int unsigned CLASS_W   = 2;
   localparam int unsigned OPC_W     = 8;
   localparam int unsigned REG_W     = 6;
   localparam int unsigned IMM_W     = 12;
   localparam int unsigned JUMP_W    = 3;
   localparam int unsigned PCCHG_W   = 9;
   localparam int unsigned PCLOC_W   = 6;

   // Bit positions inside one 16-bit instruction word
   localparam int unsigned LONG_BIT  = 15;
   localparam int unsigned CLASS_HI  = 14;
   localparam int unsigned CLASS_LO  = 13;
   localparam int unsigned OPC_HI    = 12;
   localparam int unsigned OPC_LO    = 9;
   localparam int unsigned RD_HI     = 8;
   localparam int unsigned RD_LO     = 6;
   localparam int unsigned RA_HI     = 5;
   localparam int unsigned RA_LO     = 3;
   localparam int unsigned RB_HI     = 2;
   localparam int unsigned RB_LO     = 0;

   typedef enum logic [CLASS_W-1:0] {
      CLS_ALU  = 2'b00,
      CLS_MEM  = 2'b01,
      CLS_IMM  = 2'b10,
      CLS_FLOW = 2'b11
   } dec_class_e;

   typedef enum logic [JUMP_W-1:0] {
      JMP_NONE = 3'd0,
      JMP_REL  = 3'd1,
      JMP_ABS  = 3'd2,
      JMP_JAL  = 3'd3,
      JMP_BAL  = 3'd4
   } jump_e;

   typedef enum logic {
      ST_FIRST  = 1'b0,
      ST_SECOND = 1'b1
   } dec_state_e;

   typedef struct packed {
      logic               is_long;
      dec_class_e         cls;
      logic [OPC_W-1:0]   opcode;
      logic [REG_W-1:0]   rd;
      logic [REG_W-1:0]   ra;
      logic [REG_W-1:0]   rb;
      logic [IMM_W-1:0]   imm;
      jump_e              jump;
   } dec_fields_t;

   // Flow-control class selects a PC redirect from the low opcode bits
   function automatic jump_e flow_jump(input dec_class_e cls, input logic [OPC_W-1:0] opc);
      jump_e j;
      j = JMP_NONE;
      if (cls == CLS_FLOW) begin
         case (opc[2:0])
            3'd0:    j = JMP_REL;
            3'd1:    j = JMP_ABS;
            3'd2:    j = JMP_JAL;
            3'd3:    j = JMP_BAL;
            default: j = JMP_NONE;
         endcase
      end
      return j;
   endfunction

endpackage

// File: rtl/decode_if.sv
// Fetch-to-decode bus: fetch words and pipeline controls in, decoded fields out.
interface decode_if;
   import decode_pkg::*;

   logic [FETCH_W-1:0] fetchoutput;
   logic               fetch_valid;
   logic               flush;
   logic               stall;
   logic               dec_valid;
   logic               dec_long;
   logic [CLASS_W-1:0] dec_class;
   logic [OPC_W-1:0]   dec_opcode;
   logic [REG_W-1:0]   dec_rd;
   logic [REG_W-1:0]   dec_ra;
   logic [REG_W-1:0]   dec_rb;
   logic [IMM_W-1:0]   dec_imm;
   logic [JUMP_W-1:0]  pcjumpenable;
   logic [PCCHG_W-1:0] pcchange;
   logic [PCLOC_W-1:0] pclocation;

   modport master (
      output fetchoutput, fetch_valid, flush, stall,
      input  dec_valid, dec_long, dec_class, dec_opcode, dec_rd, dec_ra, dec_rb,
             dec_imm, pcjumpenable, pcchange, pclocation
   );

   modport slave (
      input  fetchoutput, fetch_valid, flush, stall,
      output dec_valid, dec_long, dec_class, dec_opcode, dec_rd, dec_ra, dec_rb,
             dec_imm, pcjumpenable, pcchange, pclocation
   );

endinterface

// File: rtl/decode_fields.sv
// Combinational field extraction for a 16-bit word or a held-first/new-second 32-bit pair.
module decode_fields
   import decode_pkg::*;
(
   input  logic [WORD_W-1:0] held_i,
   input  logic [WORD_W-1:0] new_i,
   input  logic              long_i,
   output dec_fields_t       fields_o
);

   logic [WORD_W-1:0] first_c;
   logic              unused_c;

   // Bit 15 only steers the FSM; it carries no field data
   assign unused_c = held_i[LONG_BIT] ^ new_i[LONG_BIT];

   // Low fields come from the first word, extensions from the second
   always_comb begin
      fields_o         = '0;
      first_c          = long_i ? held_i : new_i;
      fields_o.is_long = long_i;
      fields_o.cls     = dec_class_e'(first_c[CLASS_HI:CLASS_LO]);
      if (long_i) begin
         fields_o.opcode = {new_i[OPC_HI:OPC_LO], first_c[OPC_HI:OPC_LO]};
         fields_o.rd     = {new_i[RD_HI:RD_LO], first_c[RD_HI:RD_LO]};
         fields_o.ra     = {new_i[RA_HI:RA_LO], first_c[RA_HI:RA_LO]};
         fields_o.rb     = {new_i[RB_HI:RB_LO], first_c[RB_HI:RB_LO]};
         fields_o.imm    = {new_i[RB_HI:RB_LO], first_c[RB_HI:RB_LO], new_i[RA_HI:RB_LO]};
      end else begin
         fields_o.opcode = OPC_W'(first_c[OPC_HI:OPC_LO]);
         fields_o.rd     = REG_W'(first_c[RD_HI:RD_LO]);
         fields_o.ra     = REG_W'(first_c[RA_HI:RA_LO]);
         fields_o.rb     = REG_W'(first_c[RB_HI:RB_LO]);
         fields_o.imm    = IMM_W'(first_c[RB_HI:RB_LO]);
      end
      fields_o.jump = flow_jump(fields_o.cls, fields_o.opcode);
   end

endmodule

// File: rtl/decode.sv
// Decode stage: assembles 16/32-bit instructions from fetch and registers the decoded fields.
module decode
   import decode_pkg::*;
(
   input  logic   clock,
   input  logic   reset,
   decode_if.slave bus
);

   dec_state_e        state_q;
   logic [WORD_W-1:0] held_q;
   logic              valid_q;
   dec_fields_t       fields_q;
   dec_fields_t       fields_c;
   logic [WORD_W-1:0] new_word_c;
   logic              unused_c;

   assign new_word_c = bus.fetchoutput[WORD_W-1:0];
   // The older fetch word is already captured in held_q when it matters
   assign unused_c   = ^bus.fetchoutput[FETCH_W-1:WORD_W];

   decode_fields u_fields (
      .held_i   (held_q),
      .new_i    (new_word_c),
      .long_i   (state_q == ST_SECOND),
      .fields_o (fields_c)
   );

   // FSM, held half-word and output registers; reset > flush > stall > fetch
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= ST_FIRST;
         held_q   <= '0;
         valid_q  <= 1'b0;
         fields_q <= '0;
      end else if (bus.flush) begin
         state_q       <= ST_FIRST;
         held_q        <= '0;
         valid_q       <= 1'b0;
         fields_q.jump <= JMP_NONE;
      end else if (!bus.stall) begin
         if (bus.fetch_valid) begin
            if (state_q == ST_SECOND) begin
               valid_q  <= 1'b1;
               fields_q <= fields_c;
               state_q  <= ST_FIRST;
               held_q   <= '0;
            end else if (new_word_c[LONG_BIT]) begin
               held_q        <= new_word_c;
               state_q       <= ST_SECOND;
               valid_q       <= 1'b0;
               fields_q.jump <= JMP_NONE;
            end else begin
               valid_q  <= 1'b1;
               fields_q <= fields_c;
            end
         end else begin
            valid_q       <= 1'b0;
            fields_q.jump <= JMP_NONE;
         end
      end
   end

   // Outputs are straight from registers; PC targets are slices of the immediate
   assign bus.dec_valid    = valid_q;
   assign bus.dec_long     = fields_q.is_long;
   assign bus.dec_class    = fields_q.cls;
   assign bus.dec_opcode   = fields_q.opcode;
   assign bus.dec_rd       = fields_q.rd;
   assign bus.dec_ra       = fields_q.ra;
   assign bus.dec_rb       = fields_q.rb;
   assign bus.dec_imm      = fields_q.imm;
   assign bus.pcjumpenable = fields_q.jump;
   assign bus.pcchange     = fields_q.imm[PCCHG_W-1:0];
   assign bus.pclocation   = fields_q.imm[PCLOC_W-1:0];

endmodule
